cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Upstream timing stage of cpu_control: owns the micro-cycle counter and instruction register.
//  - Counts micro-cycles per instruction; drives cycle and opcode into cpu_control.
//  - Consumes cpu_control's state combinationally in the same clock: restarts on STATE_NEXT,
//    freezes on STATE_HALT, latches the instruction byte during STATE_FETCH_INST.
//  - State codes are the shared STATE_* macros from parameters.v.
// PARAMETERS
//  CYCLE_W    4  width of cycle counter
//  MAX_CYCLE  6  last legal micro-cycle index; a step past it is a sequencing fault
//  IR_W       8  instruction register width; opcode = ir[IR_W-1 -: 4]
// PORTS
//  clk      in   1        system clock, rising edge
//  reset    in   1        asynchronous, active-high
//  state    in   4        current micro-state from cpu_control (combinational from cycle)
//  bus      in   IR_W     data bus; carries instruction byte during STATE_FETCH_INST
//  cycle    out  CYCLE_W  micro-cycle index to cpu_control
//  ir       out  IR_W     latched instruction
//  opcode   out  4        ir[IR_W-1 -: 4], to cpu_control
//  halted   out  1        CPU stopped by HLT
//  fault    out  1        sticky: counter passed MAX_CYCLE without STATE_NEXT
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-instruction): cycle=0, ir=0, halted=0, fault=0.
//    First edge after release executes cycle 0 (STATE_FETCH_PC).
//  - Per rising edge, priority order:
//    1 halted=1: all registers hold; only reset clears it.
//    2 state==STATE_HALT: halted<=1, cycle holds.
//    3 state==STATE_NEXT: cycle<=0 (next instruction's fetch starts next cycle).
//    4 cycle==MAX_CYCLE (state not NEXT/HALT): cycle<=0, fault<=1.
//    5 otherwise: cycle<=cycle+1.
//  - IR load: ir<=bus on the edge ending the STATE_FETCH_INST cycle; independent of the
//    counter action. opcode is therefore valid from cycle 2 onward (cpu_control decodes at 2).
//  - IR holds in every other state. Do not load ir while halted.
//  - cycle is plain binary, never exceeds MAX_CYCLE; no X propagation on unknown state
//    (treated as case 5).
//  - Latency: each micro-state occupies exactly one clock; instruction length = index of
//    STATE_NEXT + 1 clocks.
// CONFIGURATION
//  CPU_SINGLE_STEP_EN defined:
//    - adds input step (1b) and output waiting (1b).
//    - After STATE_NEXT the counter parks at cycle 0 with waiting=1 and does not advance.
//    - A step=1 sampled on an edge while waiting: waiting<=0, cycle 0 executes next clock.
//    - step while not waiting is ignored. Reset: waiting=1 (CPU parks before 1st instr).
//    - Halt and fault rules unchanged.
//  Not defined: ports step/waiting absent; free-running as above.
// TESTING
//  1 Reset asserted mid-cycle 3, released -> cycle=0, ir=0, halted=0, fault=0
//    asynchronously, before next edge.
//  2 LDA (bus=8'h1E at cycle 1) -> ir=8'h1E, opcode=1, cycle 0..5 then 0;
//    STATE_NEXT seen at cycle 5.
//  3 OUT then HLT (bus=8'hF0 on 2nd fetch) -> OUT wraps after cycle 3; HLT halted=1 at end of
//    cycle 2; cycle stays 2 for 20 clocks, ir stable.
//  4 Force state to non-NEXT constant for 8 clocks -> cycle 0..6, then 0 with fault=1;
//    fault stays 1 until reset.
//  5 ADD with bus changing outside cycle 1 -> ir unchanged after cycle 1 through cycle 6.
//  6 CPU_SINGLE_STEP_EN: after reset waiting=1, cycle=0 for 10 clocks; step pulse -> one full
//    instruction runs, then waiting=1 again; step held 1 mid-instruction has no effect.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: micro-cycle counter and instruction register feeding cpu_control.
// Define CPU_SINGLE_STEP_EN to add the step/waiting single-instruction gate.

`ifndef STATE_NEXT
`define STATE_NEXT 4'h0
`endif
`ifndef STATE_FETCH_PC
`define STATE_FETCH_PC 4'h1
`endif
`ifndef STATE_FETCH_INST
`define STATE_FETCH_INST 4'h2
`endif
`ifndef STATE_HALT
`define STATE_HALT 4'h3
`endif

module cpu_sequencer #(
  parameter int unsigned CYCLE_W   = 4,
  parameter int unsigned MAX_CYCLE = 6,
  parameter int unsigned IR_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  input  logic [IR_W-1:0]    bus,
`ifdef CPU_SINGLE_STEP_EN
  input  logic               step,
  output logic               waiting,
`endif
  output logic [CYCLE_W-1:0] cycle,
  output logic [IR_W-1:0]    ir,
  output logic [3:0]         opcode,
  output logic               halted,
  output logic               fault
);

  localparam logic [CYCLE_W-1:0] MaxCycle    = CYCLE_W'(MAX_CYCLE);
  localparam logic [3:0]         StNext      = `STATE_NEXT;
  localparam logic [3:0]         StFetchInst = `STATE_FETCH_INST;
  localparam logic [3:0]         StHalt      = `STATE_HALT;

  // Counter action for this edge, resolved in priority order.
  typedef enum logic [2:0] {
    ActHold,
    ActPark,
    ActHalt,
    ActRestart,
    ActFault,
    ActAdvance
  } act_e;

  act_e               act;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic               parked;

`ifdef CPU_SINGLE_STEP_EN
  logic waiting_q, waiting_d;

  assign parked  = waiting_q;
  assign waiting = waiting_q;
`else
  assign parked = 1'b0;
`endif

  // An unknown state compares false everywhere and falls through to a plain advance.
  always_comb begin
    act = ActAdvance;
    if (halted_q) begin
      act = ActHold;
    end else if (parked) begin
      act = ActPark;
    end else if (state == StHalt) begin
      act = ActHalt;
    end else if (state == StNext) begin
      act = ActRestart;
    end else if (cycle_q == MaxCycle) begin
      act = ActFault;
    end
  end

  always_comb begin
    cycle_d  = cycle_q;
    halted_d = halted_q;
    fault_d  = fault_q;
`ifdef CPU_SINGLE_STEP_EN
    waiting_d = waiting_q;
`endif
    unique case (act)
      ActHold: ;
      ActPark: begin
`ifdef CPU_SINGLE_STEP_EN
        if (step) waiting_d = 1'b0;
`endif
      end
      ActHalt: halted_d = 1'b1;
      ActRestart: begin
        cycle_d = '0;
`ifdef CPU_SINGLE_STEP_EN
        waiting_d = 1'b1;
`endif
      end
      ActFault: begin
        cycle_d = '0;
        fault_d = 1'b1;
      end
      ActAdvance: cycle_d = cycle_q + 1'b1;
      default: ;
    endcase
  end

  // The instruction byte is captured independently of what the counter does on this edge.
  always_comb begin
    ir_d = ir_q;
    if (!halted_q && !parked && (state == StFetchInst)) begin
      ir_d = bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

`ifdef CPU_SINGLE_STEP_EN
  // Parks before the first instruction after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waiting_q <= 1'b1;
    end else begin
      waiting_q <= waiting_d;
    end
  end
`endif

  assign cycle  = cycle_q;
  assign ir     = ir_q;
  assign opcode = ir_q[IR_W-1 -: 4];
  assign halted = halted_q;
  assign fault  = fault_q;

  cycle_in_range: assert property (@(posedge clk) disable iff (reset) cycle_q <= MaxCycle);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: plays cpu_control with random instruction streams and
// scoreboards every clock's outputs against an instruction-level expectation.

`ifndef STATE_NEXT
`define STATE_NEXT 4'h0
`endif
`ifndef STATE_FETCH_PC
`define STATE_FETCH_PC 4'h1
`endif
`ifndef STATE_FETCH_INST
`define STATE_FETCH_INST 4'h2
`endif
`ifndef STATE_HALT
`define STATE_HALT 4'h3
`endif

module tb_cpu_sequencer;

  localparam int MAXC = 6;
  localparam int KNormal = 0;
  localparam int KHalt = 1;
  localparam int KRunaway = 2;
  localparam logic [3:0] SNext = `STATE_NEXT;
  localparam logic [3:0] SFetchPc = `STATE_FETCH_PC;
  localparam logic [3:0] SFetchInst = `STATE_FETCH_INST;
  localparam logic [3:0] SHalt = `STATE_HALT;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic [7:0] bus;
  logic [3:0] cycle;
  logic [7:0] ir;
  logic [3:0] opcode;
  logic       halted;
  logic       fault;
`ifdef CPU_SINGLE_STEP_EN
  logic       step;
  logic       waiting;
`endif

  cpu_sequencer #(.CYCLE_W(4), .MAX_CYCLE(MAXC), .IR_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .bus    (bus),
`ifdef CPU_SINGLE_STEP_EN
    .step   (step),
    .waiting(waiting),
`endif
    .cycle  (cycle),
    .ir     (ir),
    .opcode (opcode),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cyc;
    logic [7:0] ir;
    logic       halted;
    logic       fault;
    logic       waiting;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_en = 1'b0;

  // Architectural expectation after the next edge, kept at instruction level.
  logic [7:0] cur_ir;
  logic       cur_halt, cur_fault, cur_wait;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".cycle"}, 8'(cycle), 8'(e.cyc));
    chk({tag, ".ir"}, ir, e.ir);
    chk({tag, ".opcode"}, 8'(opcode), 8'(e.ir[7:4]));
    chk({tag, ".halted"}, 8'(halted), 8'(e.halted));
    chk({tag, ".fault"}, 8'(fault), 8'(e.fault));
`ifdef CPU_SINGLE_STEP_EN
    chk({tag, ".waiting"}, 8'(waiting), 8'(e.waiting));
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard: edge with no expectation queued (t=%0t)", $time);
      end else begin
        mon_e = expq.pop_front();
        chk_all("edge", mon_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exec_state();
    return 4'($urandom_range(15, 4));
  endfunction

  function automatic exp_t now_exp(input logic [3:0] c);
    exp_t e;
    e.cyc = c;
    e.ir = cur_ir;
    e.halted = cur_halt;
    e.fault = cur_fault;
    e.waiting = cur_wait;
    return e;
  endfunction

  // Present inputs for the coming edge, queue the post-edge expectation, return at negedge.
  task automatic drive(input logic [3:0] st, input logic [7:0] b, input logic [3:0] ecyc);
    state = st;
    bus = b;
    expq.push_back(now_exp(ecyc));
    @(negedge clk);
  endtask

  // Asynchronous pulse in the low phase; checked without any clock edge.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    cur_ir = 8'h00;
    cur_halt = 1'b0;
    cur_fault = 1'b0;
    cur_wait = 1'b1;
    #1 chk_all("rst_held", now_exp(4'd0));
    #1 reset = 1'b0;
    #1 chk_all("rst_rel", now_exp(4'd0));
  endtask

`ifdef CPU_SINGLE_STEP_EN
  task automatic park(input int n);
    if (cur_wait) begin
      step = 1'b0;
      for (int i = 0; i < n; i++) drive(SFetchPc, 8'($urandom), 4'd0);
      step = 1'b1;
      cur_wait = 1'b0;
      drive(SFetchPc, 8'($urandom), 4'd0);
      step = 1'b0;
    end
  endtask
`endif

  task automatic run_instr(input int kind, input logic [7:0] op, input int nx, input int hold);
    logic [3:0] st;
    logic [7:0] b;
    logic [3:0] rc;
    if (kind == KRunaway) begin
      rc = exec_state();
      for (int k = 0; k <= MAXC; k++) begin
        if (k == MAXC) cur_fault = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
        step = 1'($urandom_range(0, 1));
`endif
        drive(rc, 8'($urandom), (k == MAXC) ? 4'd0 : 4'(k + 1));
      end
    end else begin
      for (int k = 0; k <= nx; k++) begin
        st = exec_state();
        b = 8'($urandom);
        if (k == 0) begin
          st = SFetchPc;
        end else if (k == 1) begin
          st = SFetchInst;
          b = op;
          cur_ir = op;
        end
        if (k == nx) begin
          if (kind == KHalt) begin
            st = SHalt;
            cur_halt = 1'b1;
          end else begin
            st = SNext;
            cur_wait = 1'b1;
          end
        end
`ifdef CPU_SINGLE_STEP_EN
        step = 1'($urandom_range(0, 1));
`endif
        drive(st, b, (k == nx) ? ((kind == KHalt) ? 4'(nx) : 4'd0) : 4'(k + 1));
      end
      if (kind == KHalt) begin
        for (int j = 0; j < hold; j++) drive(4'($urandom), 8'($urandom), 4'(nx));
      end
    end
`ifdef CPU_SINGLE_STEP_EN
    step = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b0;
    state = SFetchPc;
    bus = 8'h00;
`ifdef CPU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    cur_ir = 8'h00;
    cur_halt = 1'b0;
    cur_fault = 1'b0;
    cur_wait = 1'b1;
    #1 reset = 1'b1;
    #2 chk_all("por", now_exp(4'd0));
    @(negedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

`ifdef CPU_SINGLE_STEP_EN
    park(10);
`endif
    run_instr(KNormal, 8'h1E, 5, 0);             // LDA
`ifdef CPU_SINGLE_STEP_EN
    park(2);
`endif
    run_instr(KNormal, 8'hE0, 3, 0);             // OUT
`ifdef CPU_SINGLE_STEP_EN
    park(1);
`endif
    run_instr(KHalt, 8'hF0, 2, 20);              // HLT, then frozen
    pulse_reset();

    // Partial instruction, then reset while cycle 3 is executing.
`ifdef CPU_SINGLE_STEP_EN
    park(3);
`endif
    drive(SFetchPc, 8'h55, 4'd1);
    cur_ir = 8'h2A;
    drive(SFetchInst, 8'h2A, 4'd2);
    drive(exec_state(), 8'h77, 4'd3);
    pulse_reset();

`ifdef CPU_SINGLE_STEP_EN
    park(1);
`endif
    run_instr(KRunaway, 8'h00, 0, 0);
    run_instr(KNormal, 8'h2C, 6, 0);             // ADD, fault must stay set
    pulse_reset();

    for (int i = 0; i < 40; i++) begin
`ifdef CPU_SINGLE_STEP_EN
      park($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 9) == 0) run_instr(KRunaway, 8'h00, 0, 0);
      else run_instr(KNormal, 8'($urandom_range(0, 8'hEF)), $urandom_range(2, MAXC), 0);
    end
`ifdef CPU_SINGLE_STEP_EN
    park(1);
`endif
    run_instr(KHalt, 8'hF3, $urandom_range(2, MAXC), 6);

    mon_en = 1'b0;
    chk("leftover", 8'(expq.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
